mvb_delim_gen: RTL and testbench
================================

MVB_DELIM_GEN -- requirements
Module: mvb_delim_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line; the block SHALL implement all of them:
- M_LEN, 18, master-frame start delimiter length in half-bits.
- S_LEN, 18, slave-frame start delimiter length in half-bits.
- E_LEN, 4, end delimiter length in half-bits.
- M_PAT, 18'h39240, master pattern, MSB first.
- S_PAT, 18'h3FDB6, slave pattern, MSB first.
- E_PAT, 4'b0110, end pattern, MSB first.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_3M, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous reset, active-high.
- start, in, 1, request to send one delimiter.
- fmt, in, 2, format: 01 master, 10 slave, 11 end, 00 illegal.
- abort, in, 1, cancel the delimiter in progress (REQ-016 only).
- delim_out, out, 1, serial half-bit output.
- line_en, out, 1, transmitter drive enable.
- busy, out, 1, delimiter in progress.
- done, out, 1, single-cycle completion pulse.
- fmt_err, out, 1, single-cycle illegal-format pulse.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have two states: IDLE and SEND.
REQ-005 In IDLE, start=1 with fmt≠00 at cycle N SHALL latch fmt and the matching length, clear the bit counter and enter SEND.
REQ-006 In IDLE, start=1 with fmt=00 SHALL pulse fmt_err at N+1 and remain in IDLE.
REQ-007 In SEND, bit k (k=0..LEN-1) SHALL appear on delim_out at cycle N+1+k as PAT[LEN-1-k], with line_en=1 and busy=1.
REQ-008 done SHALL be 1 only in the cycle that carries bit LEN-1; the FSM SHALL return to IDLE on the following cycle.
REQ-009 In IDLE, delim_out, line_en, busy and done SHALL be 0.
REQ-010 start and fmt SHALL be ignored while busy=1, including the last-bit cycle; fmt changes during SEND SHALL NOT alter the stream.
REQ-011 Back-to-back operation: start in the first IDLE cycle after done SHALL be accepted, giving a one-cycle low gap between delimiters.
REQ-012 The bit counter width SHALL be $clog2 of the largest of M_LEN, S_LEN and E_LEN; the counter SHALL NOT wrap inside a delimiter.
REQ-013 Any LEN ≥ 1 SHALL be supported; with LEN=1, done coincides with the single bit at N+1.

Reset
REQ-014 reset=1 at any rising edge SHALL force IDLE, clear the counter and latched fmt, and drive all outputs to 0 on the next cycle, including in the middle of a delimiter.
REQ-015 reset SHALL take priority over start and abort.

Configuration
REQ-016 With macro MVB_DELIM_ABORT_EN defined: abort=1 in SEND SHALL return the FSM to IDLE next cycle with delim_out=0, line_en=0, busy=0 and no done pulse; abort=1 in IDLE has no effect; abort has priority over start in the same cycle.
REQ-017 With MVB_DELIM_ABORT_EN undefined, the abort port SHALL still exist but SHALL be ignored, and no abort logic SHALL be synthesised.

Verification
REQ-018 Master: reset released, start=1 with fmt=01 at cycle 10 -> delim_out 111001001001000000 on cycles 11-28, done=1 at cycle 28, busy=0 at cycle 29.
REQ-019 Slave followed by end: fmt=10 sent, then start with fmt=11 in the first IDLE cycle -> 111111110110110110, one cycle low, then 0110; done pulses exactly twice.
REQ-020 Illegal format and ignored start: fmt=00 -> fmt_err pulses once and busy stays 0; start at bit 5 of a master delimiter -> stream unchanged.
REQ-021 Reset mid-stream: reset=1 at bit 7 of a slave delimiter -> all outputs 0 on the next cycle; a new start after reset produces a full, correct delimiter.
REQ-022 Abort (MVB_DELIM_ABORT_EN defined): abort at bit 3 of the master delimiter -> line_en=0 next cycle and no done; with the macro undefined, the full 18 bits and done are produced.
REQ-023 Parameter sweep: M_LEN=1 with M_PAT=1'b1, and E_LEN=8 with E_PAT=8'hA5 -> patterns, timing and done match REQ-007, REQ-008 and REQ-013.

Source files
------------

// File: rtl/mvb_delim_gen.sv
// MVB start/end delimiter serializer: shifts out one half-bit pattern per clk_3M cycle.
// Optional abort of a delimiter in progress is enabled with `define MVB_DELIM_ABORT_EN.
module mvb_delim_gen #(
  parameter int                M_LEN = 18,
  parameter int                S_LEN = 18,
  parameter int                E_LEN = 4,
  parameter logic [M_LEN-1:0]  M_PAT = 18'h39240,
  parameter logic [S_LEN-1:0]  S_PAT = 18'h3FDB6,
  parameter logic [E_LEN-1:0]  E_PAT = 4'b0110
) (
  input  logic       clk_3M,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] fmt,
  input  logic       abort,
  output logic       delim_out,
  output logic       line_en,
  output logic       busy,
  output logic       done,
  output logic       fmt_err
);

  localparam int MS_LEN  = (M_LEN > S_LEN) ? M_LEN : S_LEN;
  localparam int MAX_LEN = (MS_LEN > E_LEN) ? MS_LEN : E_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Patterns left-justified to a common width so bit k is always the MSB after a shift by k.
  localparam logic [MAX_LEN-1:0] M_AL = MAX_LEN'(M_PAT) << (MAX_LEN - M_LEN);
  localparam logic [MAX_LEN-1:0] S_AL = MAX_LEN'(S_PAT) << (MAX_LEN - S_LEN);
  localparam logic [MAX_LEN-1:0] E_AL = MAX_LEN'(E_PAT) << (MAX_LEN - E_LEN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] last_q;
  logic [1:0]       fmt_q;

  function automatic logic pat_bit(input logic [1:0] f, input logic [CNT_W-1:0] k);
    logic [MAX_LEN-1:0] al;
    case (f)
      2'b01:   al = M_AL;
      2'b10:   al = S_AL;
      default: al = E_AL;
    endcase
    al = al << k;
    return al[MAX_LEN-1];
  endfunction

  function automatic logic [CNT_W-1:0] len_last(input logic [1:0] f);
    case (f)
      2'b01:   return CNT_W'(M_LEN - 1);
      2'b10:   return CNT_W'(S_LEN - 1);
      default: return CNT_W'(E_LEN - 1);
    endcase
  endfunction

  assign cnt_nxt = cnt + 1'b1;

`ifndef MVB_DELIM_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_ff @(posedge clk_3M) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= '0;
      fmt_q     <= '0;
      delim_out <= 1'b0;
      line_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      fmt_err <= 1'b0;
      case (state)
        IDLE: begin
          delim_out <= 1'b0;
          line_en   <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            if (fmt == 2'b00) begin
              fmt_err <= 1'b1;
            end else begin
              // Bit 0 is registered here so it appears in the cycle right after start.
              state     <= SEND;
              fmt_q     <= fmt;
              last_q    <= len_last(fmt);
              cnt       <= '0;
              delim_out <= pat_bit(fmt, '0);
              line_en   <= 1'b1;
              busy      <= 1'b1;
              done      <= (len_last(fmt) == '0);
            end
          end
        end
        SEND: begin
`ifdef MVB_DELIM_ABORT_EN
          if (abort) begin
            state     <= IDLE;
            delim_out <= 1'b0;
            line_en   <= 1'b0;
            busy      <= 1'b0;
          end else
`endif
          if (cnt == last_q) begin
            state     <= IDLE;
            delim_out <= 1'b0;
            line_en   <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt       <= cnt_nxt;
            delim_out <= pat_bit(fmt_q, cnt_nxt);
            done      <= (cnt_nxt == last_q);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvb_delim_gen.sv
// Directed bench for mvb_delim_gen: default instance plus a short-master / 8-bit-end instance.
module tb_mvb_delim_gen;

  logic       clk_3M = 1'b0;
  logic       reset  = 1'b1;
  logic       abort  = 1'b0;
  logic       start_m = 1'b0, start_p = 1'b0;
  logic [1:0] fmt_m = 2'b00, fmt_p = 2'b00;
  logic       d_m, l_m, b_m, dn_m, e_m;
  logic       d_p, l_p, b_p, dn_p, e_p;
  int         n_tests = 0;
  int         n_fail  = 0;

`ifdef MVB_DELIM_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  always #5 clk_3M = ~clk_3M;

  mvb_delim_gen dut_m (
    .clk_3M(clk_3M), .reset(reset), .start(start_m), .fmt(fmt_m), .abort(abort),
    .delim_out(d_m), .line_en(l_m), .busy(b_m), .done(dn_m), .fmt_err(e_m)
  );

  mvb_delim_gen #(.M_LEN(1), .M_PAT(1'b1), .E_LEN(8), .E_PAT(8'hA5)) dut_p (
    .clk_3M(clk_3M), .reset(reset), .start(start_p), .fmt(fmt_p), .abort(1'b0),
    .delim_out(d_p), .line_en(l_p), .busy(b_p), .done(dn_p), .fmt_err(e_p)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [1:0] f);
    if (sel) begin start_p = st; fmt_p = f; end
    else     begin start_m = st; fmt_m = f; end
  endtask

  task automatic out_chk(input bit sel, input string tag, input logic d, input logic l,
                         input logic b, input logic dn);
    check({tag, " delim"},   sel ? d_p  : d_m,  d);
    check({tag, " line_en"}, sel ? l_p  : l_m,  l);
    check({tag, " busy"},    sel ? b_p  : b_m,  b);
    check({tag, " done"},    sel ? dn_p : dn_m, dn);
  endtask

  // Called just after a negedge; start is raised in the current cycle.
  // stop_kind: 1 = reset at bit stop_at, 2 = abort at bit stop_at.
  task automatic send(input bit sel, input string name, input logic [1:0] f,
                      input logic [31:0] pat, input int len, input int inj_at,
                      input int stop_at, input int stop_kind);
    logic [31:0] tmp;
    drive(sel, 1'b1, f);
    for (int k = 0; k < len; k++) begin
      @(negedge clk_3M);
      drive(sel, 1'b0, sel ? fmt_p : fmt_m);
      reset = 1'b0;
      abort = 1'b0;
      tmp = pat >> (len - 1 - k);
      out_chk(sel, $sformatf("%s b%0d", name, k), tmp[0], 1'b1, 1'b1, k == len - 1);
      if (k == inj_at) drive(sel, 1'b1, 2'b10);
      if (k == stop_at) begin
        if (stop_kind == 1) reset = 1'b1;
        else                abort = 1'b1;
        if (stop_kind == 1 || ABORT_ON) break;
      end
    end
    @(negedge clk_3M);
    drive(sel, 1'b0, sel ? fmt_p : fmt_m);
    reset = 1'b0;
    abort = 1'b0;
    out_chk(sel, {name, " end"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk_3M);
    out_chk(0, "rst_m", 1'b0, 1'b0, 1'b0, 1'b0);
    out_chk(1, "rst_p", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst fmt_err", e_m, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk_3M);

    // Master with a stray start/fmt change at bit 5, then at the last bit.
    send(0, "mst", 2'b01, 32'h39240, 18, 5, -1, 0);
    send(0, "mst_last", 2'b01, 32'h39240, 18, 17, -1, 0);
    @(negedge clk_3M);

    // Slave followed back-to-back by end delimiter.
    send(0, "slv", 2'b10, 32'h3FDB6, 18, -1, -1, 0);
    send(0, "end", 2'b11, 32'h6, 4, -1, -1, 0);

    // Illegal format.
    drive(0, 1'b1, 2'b00);
    @(negedge clk_3M);
    drive(0, 1'b0, 2'b00);
    check("ferr pulse", e_m, 1'b1);
    check("ferr busy", b_m, 1'b0);
    @(negedge clk_3M);
    check("ferr single", e_m, 1'b0);
    check("ferr busy2", b_m, 1'b0);

    // Reset in the middle of a slave, then a full master.
    send(0, "slv_rst", 2'b10, 32'h3FDB6, 18, -1, 7, 1);
    check("slv_rst ferr", e_m, 1'b0);
    send(0, "mst_after", 2'b01, 32'h39240, 18, -1, -1, 0);

    // Abort at bit 3 (ignored unless the abort feature is built in).
    send(0, "abt", 2'b01, 32'h39240, 18, -1, 3, 2);
    @(negedge clk_3M);
    out_chk(0, "abt idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Parameter sweep instance: one-bit master back-to-back, 8-bit end, default slave.
    send(1, "p_m1", 2'b01, 32'h1, 1, -1, -1, 0);
    send(1, "p_m1b", 2'b01, 32'h1, 1, -1, -1, 0);
    send(1, "p_e8", 2'b11, 32'hA5, 8, -1, -1, 0);
    send(1, "p_slv", 2'b10, 32'h3FDB6, 18, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
